// File: rtl/video_fetch_fifo.sv
// Packs 16-bit DRAM video words into WORDS*16-bit fetch words and queues them in a
// DEPTH-entry FIFO drained by the renderer's fetch_stb, with level/overrun/underrun.
module video_fetch_fifo #(
   parameter int WORDS = 2,
   parameter int DEPTH = 4,
   parameter int FW    = WORDS * 16,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic [1:0]    mode,
   input  logic          video_strobe,
   input  logic [15:0]   video_data,
   input  logic          fetch_stb,
   output logic [FW-1:0] fetch_data,
   output logic          fetch_valid,
   output logic [LW-1:0] level,
   output logic          dram_req,
   output logic          overrun,
   output logic          underrun
);

   // Handshakes: video_strobe marks video_data valid for exactly one cycle and is
   // never back-pressured (a full FIFO drops the word and flags overrun); fetch_stb
   // is a one-cycle pop request answered by fetch_data/fetch_valid one clock later.

   localparam int NB  = 2 * WORDS;
   localparam int PW  = $clog2(NB);
   localparam int PW1 = PW + 1;
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0]  ptr;
   logic [1:0]     cur_mode;
   logic [FW-1:0]  asm_reg;
   logic [FW-1:0]  mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;

   logic [1:0]     eff_mode;
   logic           word_mode;
   logic [7:0]     sel_byte;
   logic [PW1-1:0] ptr_sum;
   logic [PW1-1:0] ptr_p1;
   logic           complete;
   logic [FW-1:0]  asm_next;
   logic           full;
   logic           empty;
   logic           pop;
   logic           push_req;
   logic           push;
   logic           drop;

   // The mode presented with the first strobe of a word governs the whole word.
   assign eff_mode  = (ptr == '0) ? mode : cur_mode;
   assign word_mode = (eff_mode == 2'd0) || (eff_mode == 2'd3);
   assign sel_byte  = (eff_mode == 2'd2) ? video_data[15:8] : video_data[7:0];
   assign ptr_sum   = {1'b0, ptr} + (word_mode ? PW1'(2) : PW1'(1));
   assign ptr_p1    = {1'b0, ptr} + PW1'(1);
   assign complete  = (ptr_sum == PW1'(NB));

   always_comb begin
      asm_next = asm_reg;
      for (int k = 0; k < NB; k++) begin
         if (PW'(k) == ptr)
            asm_next[8*k +: 8] = word_mode ? video_data[7:0] : sel_byte;
         if (word_mode && (PW1'(k) == ptr_p1))
            asm_next[8*k +: 8] = video_data[15:8];
      end
   end

   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign pop      = fetch_stb && !empty;
   assign push_req = video_strobe && complete;
   // A pop in the same cycle frees the slot the completing word needs.
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;
   assign dram_req = (level < LW'(DEPTH));

   always_ff @(posedge clk) begin
      if (push && !clr)
         mem[wr_ptr] <= asm_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr         <= '0;
         cur_mode    <= 2'd0;
         asm_reg     <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         level       <= '0;
         fetch_data  <= '0;
         fetch_valid <= 1'b0;
         overrun     <= 1'b0;
         underrun    <= 1'b0;
      end else if (clr) begin
         ptr         <= '0;
         cur_mode    <= 2'd0;
         asm_reg     <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         level       <= '0;
         fetch_data  <= '0;
         fetch_valid <= 1'b0;
         overrun     <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         if (video_strobe) begin
            if (ptr == '0)
               cur_mode <= mode;
            if (complete) begin
               ptr     <= '0;
               asm_reg <= '0;
            end else begin
               ptr     <= ptr_sum[PW-1:0];
               asm_reg <= asm_next;
            end
         end
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (drop)
            overrun <= 1'b1;
         if (pop) begin
            fetch_data <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + AW'(1);
         end
         fetch_valid <= pop;
         if (fetch_stb && empty)
            underrun <= 1'b1;
         if (push && !pop)
            level <= level + LW'(1);
         else if (pop && !push)
            level <= level - LW'(1);
      end
   end

endmodule

// File: tb/tb_video_fetch_fifo.sv
// Directed bench for video_fetch_fifo (WORDS=2, DEPTH=4): packing modes, FIFO order,
// overrun/underrun, same-cycle push/pop at full, sync clear and async reset.
module tb_video_fetch_fifo;

   localparam int FW = 32;
   localparam int LW = 3;

   logic          clk;
   logic          rst_n;
   logic          clr;
   logic [1:0]    mode;
   logic          video_strobe;
   logic [15:0]   video_data;
   logic          fetch_stb;
   logic [FW-1:0] fetch_data;
   logic          fetch_valid;
   logic [LW-1:0] level;
   logic          dram_req;
   logic          overrun;
   logic          underrun;

   int passed = 0;
   int total  = 0;

   video_fetch_fifo #(.WORDS(2), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode),
      .video_strobe(video_strobe), .video_data(video_data), .fetch_stb(fetch_stb),
      .fetch_data(fetch_data), .fetch_valid(fetch_valid), .level(level),
      .dram_req(dram_req), .overrun(overrun), .underrun(underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [1:0] m, input logic [15:0] d);
      mode = m;
      video_strobe = 1'b1;
      video_data = d;
      cyc();
      video_strobe = 1'b0;
   endtask

   task automatic pop();
      fetch_stb = 1'b1;
      cyc();
      fetch_stb = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] w);
      strobe(2'd0, w[15:0]);
      strobe(2'd0, w[31:16]);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_data"}, 64'(fetch_data), 64'h0);
      check({tag, "_valid"}, 64'(fetch_valid), 64'h0);
      check({tag, "_level"}, 64'(level), 64'h0);
      check({tag, "_req"}, 64'(dram_req), 64'h1);
      check({tag, "_ovr"}, 64'(overrun), 64'h0);
      check({tag, "_udr"}, 64'(underrun), 64'h0);
   endtask

   function automatic logic [31:0] wpat(input int n);
      return {16'(n * 16'h1010), 16'(n * 16'h0101)};
   endfunction

   initial begin
      rst_n = 1'b0; clr = 1'b0; mode = 2'd0;
      video_strobe = 1'b0; video_data = 16'h0; fetch_stb = 1'b0;
      #3;
      check_idle("reset");
      #4 rst_n = 1'b1;
      cyc();

      // Word mode packing.
      strobe(2'd0, 16'h1122);
      check("word_lvl_half", 64'(level), 64'd0);
      strobe(2'd0, 16'h3344);
      check("word_lvl_full", 64'(level), 64'd1);
      pop();
      check("word_data", 64'(fetch_data), 64'h33441122);
      check("word_valid", 64'(fetch_valid), 64'h1);
      check("word_lvl_pop", 64'(level), 64'd0);
      cyc();
      check("valid_drop", 64'(fetch_valid), 64'h0);
      check("valid_hold_data", 64'(fetch_data), 64'h33441122);

      // High-byte mode; later mode changes mid-word are ignored.
      strobe(2'd2, 16'hAA01);
      strobe(2'd0, 16'hBB02);
      strobe(2'd0, 16'hCC03);
      strobe(2'd0, 16'hDD04);
      check("b2_lvl", 64'(level), 64'd1);
      pop();
      check("b2_data", 64'(fetch_data), 64'hDDCCBBAA);

      // Low-byte mode.
      strobe(2'd1, 16'hFF12);
      strobe(2'd1, 16'hFF34);
      strobe(2'd1, 16'hFF56);
      strobe(2'd1, 16'hFF78);
      pop();
      check("b1_data", 64'(fetch_data), 64'h78563412);

      // Fill past full: fifth word dropped.
      for (int n = 1; n <= 5; n++) push_word(wpat(n));
      check("fill_lvl", 64'(level), 64'd4);
      check("fill_req", 64'(dram_req), 64'h0);
      check("fill_ovr", 64'(overrun), 64'h1);
      for (int n = 1; n <= 4; n++) begin
         pop();
         check($sformatf("drain_%0d", n), 64'(fetch_data), 64'(wpat(n)));
      end
      check("drain_lvl", 64'(level), 64'd0);
      check("drain_req", 64'(dram_req), 64'h1);
      check("pre_udr", 64'(underrun), 64'h0);
      pop();
      check("udr_flag", 64'(underrun), 64'h1);
      check("udr_hold", 64'(fetch_data), 64'(wpat(4)));
      check("udr_valid", 64'(fetch_valid), 64'h0);
      check("udr_lvl", 64'(level), 64'd0);

      clr = 1'b1;
      cyc();
      clr = 1'b0;
      check_idle("clr1");

      // Completing strobe and pop together at full.
      for (int n = 1; n <= 4; n++) push_word(wpat(n));
      strobe(2'd0, wpat(5)[15:0]);
      mode = 2'd0; video_strobe = 1'b1; video_data = wpat(5)[31:16]; fetch_stb = 1'b1;
      cyc();
      video_strobe = 1'b0; fetch_stb = 1'b0;
      check("pp_lvl", 64'(level), 64'd4);
      check("pp_ovr", 64'(overrun), 64'h0);
      check("pp_data", 64'(fetch_data), 64'(wpat(1)));
      check("pp_valid", 64'(fetch_valid), 64'h1);
      for (int n = 2; n <= 5; n++) begin
         pop();
         check($sformatf("pp_drain_%0d", n), 64'(fetch_data), 64'(wpat(n)));
      end

      // Sync clear mid-word with a simultaneous pop request.
      push_word(32'hDEADBEEF);
      strobe(2'd0, 16'h5566);
      clr = 1'b1; fetch_stb = 1'b1;
      cyc();
      clr = 1'b0; fetch_stb = 1'b0;
      check_idle("clr2");
      strobe(2'd0, 16'h7788);
      check("clr2_half", 64'(level), 64'd0);
      strobe(2'd0, 16'h99AA);
      pop();
      check("clr2_word", 64'(fetch_data), 64'h99AA7788);

      // Empty pop coinciding with a completing push: no bypass, push still lands.
      strobe(2'd0, 16'h0102);
      mode = 2'd0; video_strobe = 1'b1; video_data = 16'h0304; fetch_stb = 1'b1;
      cyc();
      video_strobe = 1'b0; fetch_stb = 1'b0;
      check("nobyp_data", 64'(fetch_data), 64'h99AA7788);
      check("nobyp_valid", 64'(fetch_valid), 64'h0);
      check("nobyp_udr", 64'(underrun), 64'h1);
      check("nobyp_lvl", 64'(level), 64'd1);

      // Asynchronous reset mid-word, between clock edges.
      push_word(32'h13572468);
      strobe(2'd0, 16'hABCD);
      #2 rst_n = 1'b0;
      #1;
      check_idle("areset");
      #1 rst_n = 1'b1;
      cyc();
      strobe(2'd0, 16'hCAFE);
      strobe(2'd0, 16'hF00D);
      pop();
      check("post_rst_word", 64'(fetch_data), 64'hF00DCAFE);
      check("post_rst_lvl", 64'(level), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
